// File: rtl/mips_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int DEFAULT_IMEM_BYTES = 64;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: reset beats squash, squash beats hold, otherwise load.
module ifid_reg
  import mips_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              squash_i,
  input  logic [WORD_W-1:0] instr_i,
  input  logic [WORD_W-1:0] pc4_i,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] pc4_o,
  output logic              valid_o
);

  logic [WORD_W-1:0] instr_q;
  logic [WORD_W-1:0] pc4_q;
  logic              valid_q;

  // A squash only kills the valid bit; the stale payload is harmless behind it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (squash_i) begin
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, RUN/FAULT control and the IF/ID register feeding decode.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_BYTES = DEFAULT_IMEM_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  // Highest byte address that still holds a full word.
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_BYTES - 4);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  faultPc_q, faultPc_d;
  logic [31:0]  fetchCount_q, fetchCount_d;
  logic [31:0]  pcPlus4;
  logic         ifidHold;
  logic         ifidSquash;

  assign pcPlus4 = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      faultPc_q    <= '0;
      fetchCount_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      faultPc_q    <= faultPc_d;
      fetchCount_q <= fetchCount_d;
    end
  end

  // Redirect outranks stall so a taken branch is never lost behind a hazard.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    faultPc_d    = faultPc_q;
    fetchCount_d = fetchCount_q;
    ifidHold     = 1'b0;
    ifidSquash   = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect) begin
          ifidSquash = 1'b1;
          if (redirect_pc[1:0] == 2'b00) begin
            pc_d = redirect_pc;
          end else begin
            state_d   = FAULT;
            faultPc_d = redirect_pc;
          end
        end else if (stall) begin
          ifidHold = 1'b1;
        end else if (pc_q > PC_LIMIT) begin
          state_d    = FAULT;
          faultPc_d  = pc_q;
          ifidSquash = 1'b1;
        end else begin
          pc_d = pcPlus4;
          if (fetchCount_q != 32'hFFFF_FFFF) begin
            fetchCount_d = fetchCount_q + 32'd1;
          end
        end
      end
      FAULT: begin
        ifidSquash = 1'b1;
      end
      default: begin
        state_d    = FAULT;
        ifidSquash = 1'b1;
      end
    endcase
  end

  ifid_reg uIfid (
    .clk_i    (clk),
    .rst_i    (rst),
    .hold_i   (ifidHold),
    .squash_i (ifidSquash),
    .instr_i  (imem_instr),
    .pc4_i    (pcPlus4),
    .instr_o  (ifid_instr),
    .pc4_o    (ifid_pc4),
    .valid_o  (ifid_valid)
  );

  assign imem_addr   = pc_q;
  assign fault       = (state_q == FAULT);
  assign fault_pc    = faultPc_q;
  assign fetch_count = fetchCount_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a rule-level model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;
  logic [31:0] imemAddr;
  logic [31:0] imemInstr;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPc4;
  logic        ifidValid;
  logic        fault;
  logic [31:0] faultPc;
  logic [31:0] fetchCount;

  int nCompared;
  int nMismatched;

  logic [31:0] mem [16];

  // Reference model state, advanced from the behavioural rules once per clock.
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mPc4;
  logic        mValid;
  logic        mFault;
  logic [31:0] mFaultPc;
  logic [31:0] mCount;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirectPc),
    .imem_addr   (imemAddr),
    .imem_instr  (imemInstr),
    .ifid_instr  (ifidInstr),
    .ifid_pc4    (ifidPc4),
    .ifid_valid  (ifidValid),
    .fault       (fault),
    .fault_pc    (faultPc),
    .fetch_count (fetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imemInstr = (imemAddr < 32'd64) ? mem[imemAddr[5:2]] : 32'hBAD0_BAD0;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr < 32'd64) return mem[addr[5:2]];
    return 32'hBAD0_BAD0;
  endfunction

  // Drives one cycle of inputs, advances the model, and lands 1ns after the edge.
  task automatic tick(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    rst        = r;
    stall      = s;
    redirect   = rd;
    redirectPc = rpc;
    if (r) begin
      mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
      mFault = 1'b0; mFaultPc = 32'h0; mCount = 32'h0;
    end else if (mFault) begin
      mValid = 1'b0;
    end else if (rd) begin
      mValid = 1'b0;
      if (rpc % 4 == 0) mPc = rpc;
      else begin
        mFault = 1'b1; mFaultPc = rpc;
      end
    end else if (s) begin
      // everything holds
    end else if (mPc > 32'd60) begin
      mFault = 1'b1; mFaultPc = mPc; mValid = 1'b0;
    end else begin
      mInstr = memWord(mPc);
      mPc4   = mPc + 32'd4;
      mPc    = mPc + 32'd4;
      mValid = 1'b1;
      if (mCount != 32'hFFFF_FFFF) mCount = mCount + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic loadDirectedMem();
    for (int i = 0; i < 16; i++) begin
      if (i < 4) mem[i] = 32'h1111_1111 * (i + 1);
      else mem[i] = {16'hC0DE, 16'(i * 4)};
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    nCompared++;
    if (imemAddr !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_pc: got %h want %h", imemAddr, 32'h0); end
    nCompared++;
    if (ifidValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b want 0", ifidValid); end
    nCompared++;
    if (fault !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_fault: got %b want 0", fault); end
    nCompared++;
    if (fetchCount !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_count: got %0d want 0", fetchCount); end
    nCompared++;
    if (ifidInstr !== 32'h0 || ifidPc4 !== 32'h0 || faultPc !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_regs: got instr %h pc4 %h faultpc %h want all 0", ifidInstr, ifidPc4, faultPc);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      nCompared++;
      if (ifidInstr !== 32'h1111_1111 * (i + 1) || ifidPc4 !== 32'(4 * (i + 1)) || ifidValid !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL seq_%0d: got instr %h pc4 %h valid %b want %h %h 1", i, ifidInstr, ifidPc4,
                 ifidValid, 32'h1111_1111 * (i + 1), 32'(4 * (i + 1)));
      end
    end
    nCompared++;
    if (fetchCount !== 32'd4) begin nMismatched++; $display("[TB] FAIL seq_count: got %0d want 4", fetchCount); end
  endtask

  task automatic test_stall();
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      nCompared++;
      if (imemAddr !== 32'd8 || ifidInstr !== 32'h2222_2222 || ifidPc4 !== 32'd8 || ifidValid !== 1'b1 || fetchCount !== 32'd2) begin
        nMismatched++;
        $display("[TB] FAIL stall_hold_%0d: got addr %h instr %h pc4 %h valid %b count %0d want 8 22222222 8 1 2",
                 i, imemAddr, ifidInstr, ifidPc4, ifidValid, fetchCount);
      end
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    nCompared++;
    if (ifidInstr !== 32'h3333_3333 || ifidPc4 !== 32'd12 || ifidValid !== 1'b1 || fetchCount !== 32'd3) begin
      nMismatched++;
      $display("[TB] FAIL stall_resume: got instr %h pc4 %h valid %b count %0d want 33333333 c 1 3",
               ifidInstr, ifidPc4, ifidValid, fetchCount);
    end
  endtask

  task automatic test_redirect_stall();
    tick(1'b0, 1'b1, 1'b1, 32'h20);
    nCompared++;
    if (imemAddr !== 32'h20 || ifidValid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL redir_stall: got addr %h valid %b want 20 0", imemAddr, ifidValid);
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    nCompared++;
    if (ifidInstr !== 32'hC0DE_0020 || ifidPc4 !== 32'h24 || ifidValid !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL redir_target: got instr %h pc4 %h valid %b want c0de0020 24 1", ifidInstr, ifidPc4, ifidValid);
    end
  endtask

  task automatic test_misaligned();
    tick(1'b0, 1'b0, 1'b1, 32'h22);
    nCompared++;
    if (fault !== 1'b1 || faultPc !== 32'h22 || ifidValid !== 1'b0 || imemAddr !== 32'h24) begin
      nMismatched++;
      $display("[TB] FAIL misalign_entry: got fault %b faultpc %h valid %b addr %h want 1 22 0 24",
               fault, faultPc, ifidValid, imemAddr);
    end
    tick(1'b0, 1'b0, 1'b1, 32'h10);
    tick(1'b0, 1'b1, 1'b1, 32'h08);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    nCompared++;
    if (fault !== 1'b1 || faultPc !== 32'h22 || imemAddr !== 32'h24 || ifidValid !== 1'b0 || fetchCount !== mCount) begin
      nMismatched++;
      $display("[TB] FAIL misalign_sticky: got fault %b faultpc %h addr %h valid %b count %0d want 1 22 24 0 %0d",
               fault, faultPc, imemAddr, ifidValid, fetchCount, mCount);
    end
  endtask

  task automatic test_reset_from_fault();
    tick(1'b1, 1'b1, 1'b1, 32'h33);
    nCompared++;
    if (fault !== 1'b0 || imemAddr !== 32'h0 || fetchCount !== 32'h0 || faultPc !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL fault_reset: got fault %b addr %h count %0d faultpc %h want 0 0 0 0",
               fault, imemAddr, fetchCount, faultPc);
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    nCompared++;
    if (ifidValid !== 1'b1 || ifidInstr !== 32'h1111_1111 || fetchCount !== 32'd1) begin
      nMismatched++;
      $display("[TB] FAIL fault_resume: got valid %b instr %h count %0d want 1 11111111 1", ifidValid, ifidInstr, fetchCount);
    end
  endtask

  task automatic test_out_of_range();
    tick(1'b0, 1'b0, 1'b1, 32'd56);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    nCompared++;
    if (ifidInstr !== 32'hC0DE_003C || ifidPc4 !== 32'd64 || ifidValid !== 1'b1 || fault !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL range_last: got instr %h pc4 %h valid %b fault %b want c0de003c 40 1 0",
               ifidInstr, ifidPc4, ifidValid, fault);
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    nCompared++;
    if (fault !== 1'b1 || faultPc !== 32'h40 || ifidValid !== 1'b0 || fetchCount !== 32'd3) begin
      nMismatched++;
      $display("[TB] FAIL range_fault: got fault %b faultpc %h valid %b count %0d want 1 40 0 3",
               fault, faultPc, ifidValid, fetchCount);
    end
  endtask

  task automatic test_random();
    logic        r, s, rd;
    logic [31:0] rpc;
    int          pick;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 400; c++) begin
      r    = ($urandom_range(0, 49) == 0);
      s    = ($urandom_range(0, 3) == 0);
      rd   = ($urandom_range(0, 9) == 0);
      pick = $urandom_range(0, 9);
      if (pick < 6) rpc = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      else if (pick < 8) rpc = {$urandom} | 32'h1;
      else if (pick == 8) rpc = 32'h0000_0100;
      else rpc = 32'hFFFF_FFFC;
      tick(r, s, rd, rpc);
      nCompared++;
      if (imemAddr !== mPc || ifidInstr !== mInstr || ifidPc4 !== mPc4 || ifidValid !== mValid ||
          fault !== mFault || faultPc !== mFaultPc || fetchCount !== mCount) begin
        nMismatched++;
        $display("[TB] FAIL random_%0d: got addr %h instr %h pc4 %h v %b f %b fpc %h cnt %0d want %h %h %h %b %b %h %0d",
                 c, imemAddr, ifidInstr, ifidPc4, ifidValid, fault, faultPc, fetchCount,
                 mPc, mInstr, mPc4, mValid, mFault, mFaultPc, mCount);
      end
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = 32'h0;
    loadDirectedMem();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_misaligned();
    test_reset_from_fault();
    test_out_of_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_BYTES, default 64, meaning instruction-memory size in bytes.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-005 SHALL have port stall, input, 1, meaning hold PC and IF/ID contents this cycle.
REQ-006 SHALL have port redirect, input, 1, meaning taken branch/jump; load redirect_pc.
REQ-007 SHALL have port redirect_pc, input, 32, meaning byte address of the redirect target.
REQ-008 SHALL have port imem_addr, output, 32, meaning byte address driven to instruction memory (Raddr).
REQ-009 SHALL have port imem_instr, input, 32, meaning little-endian word returned combinationally by instruction memory.
REQ-010 SHALL have port ifid_instr, output, 32, meaning registered instruction to decode.
REQ-011 SHALL have port ifid_pc4, output, 32, meaning registered PC+4 of that instruction.
REQ-012 SHALL have port ifid_valid, output, 1, meaning ifid_instr holds a real instruction (0 = bubble).
REQ-013 SHALL have port fault, output, 1, meaning sticky fetch fault.
REQ-014 SHALL have port fault_pc, output, 32, meaning offending address captured at fault entry.
REQ-015 SHALL have port fetch_count, output, 32, meaning number of instructions latched valid into IF/ID.

Function
REQ-016 SHALL drive imem_addr combinationally from the PC register (zero added latency; instruction latched same cycle).
REQ-017 SHALL implement FSM states RUN and FAULT; RUN after reset.
REQ-018 In RUN, priority SHALL be: rst > redirect > stall > normal fetch.
REQ-019 Normal fetch (RUN, no stall, no redirect, PC in range): pc <= pc+4; ifid_instr <= imem_instr; ifid_pc4 <= pc+4; ifid_valid <= 1; fetch_count += 1.
REQ-020 Stall without redirect: PC, ifid_instr, ifid_pc4, ifid_valid, fetch_count SHALL hold.
REQ-021 Redirect with redirect_pc[1:0]==0: pc <= redirect_pc; ifid_valid <= 0 (squash), regardless of stall.
REQ-022 Redirect with redirect_pc[1:0]!=0: SHALL enter FAULT, fault_pc <= redirect_pc, PC unchanged, ifid_valid <= 0.
REQ-023 Out-of-range PC (pc > IMEM_BYTES-4) in RUN, no redirect, no stall: SHALL enter FAULT, fault_pc <= pc, ifid_valid <= 0, fetch_count unchanged.
REQ-024 Range check SHALL use unsigned 32-bit compare; pc+4 wraps modulo 2^32 but range check precedes any wrap.
REQ-025 In FAULT: fault=1; PC, fault_pc, fetch_count hold; ifid_valid=0; stall and redirect ignored; exit only via rst.
REQ-026 fetch_count SHALL saturate at 32'hFFFF_FFFF.
REQ-027 Redirect during a stall cycle SHALL NOT lose the redirect; PC loads target in that same cycle.

Reset
REQ-028 On rst=1 at clock edge: pc=RESET_PC, state=RUN, ifid_instr=0, ifid_pc4=0, ifid_valid=0, fault=0, fault_pc=0, fetch_count=0.
REQ-029 Reset mid-operation (including FAULT or stall) SHALL override all other inputs that cycle.
REQ-030 First valid IF/ID entry SHALL appear one clock after rst deasserts, holding the word at RESET_PC.

Structure
REQ-031 Shared package mips_pkg SHALL hold the fetch_state_t enum (RUN, FAULT), WORD_W=32, and default RESET_PC / IMEM_BYTES constants.
REQ-032 One sub-module ifid_reg (IF/ID pipeline register with hold and squash inputs) SHALL be instantiated; PC register and FSM stay in fetch_unit.
REQ-033 Instruction memory SHALL remain external, connected via imem_addr/imem_instr.

Verification
REQ-034 Reset then 4 free-running cycles with words 0x11111111..0x44444444 at 0,4,8,12 -> ifid_instr sequence 0x11111111..0x44444444, ifid_pc4 4,8,12,16, fetch_count=4.
REQ-035 stall=1 for 3 cycles at pc=8 -> imem_addr stays 8, IF/ID and fetch_count unchanged; resumes with word at 8 one cycle after stall drops.
REQ-036 redirect=1, redirect_pc=0x20 together with stall=1 -> next cycle imem_addr=0x20, ifid_valid=0; following cycle ifid_instr=mem word at 0x20, ifid_pc4=0x24.
REQ-037 redirect_pc=0x0000_0022 -> fault=1, fault_pc=0x22, ifid_valid=0; further redirects ignored until rst.
REQ-038 Sequential run to pc=60 then 64 with IMEM_BYTES=64 -> word at 60 latched valid, then fault=1, fault_pc=0x40.
REQ-039 rst asserted while in FAULT -> next cycle fault=0, pc=RESET_PC, fetch_count=0, normal fetch resumes.
